// File: rtl/lzw_pkg.sv
// Shared LZW decoder constants and the string-unwind FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lzw_pkg;

    localparam int CODE_W    = 12;
    localparam int DATA_W    = 8;
    // Codes below this value are literal characters, not dictionary entries.
    localparam int LIT_LIMIT = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WALK   = 2'd2,
        POP    = 2'd3
    } state_t;

endpackage

// File: rtl/lzw_char_stack.sv
// Character LIFO with count/full/empty and a registered, prefetched top-of-stack.
// Latency: top reflects a push or pop on the following cycle; no bubble between pops.
// Backpressure: push while full and pop while empty are ignored; caller never pushes and pops together.
module lzw_char_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] top_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] below_ptr;

    // Slot for the next push, and the slot that becomes top after a pop.
    // At count==DEPTH the pointer bits wrap to 0, so below_ptr still lands on DEPTH-2.
    assign wr_ptr    = cnt_q[PTR_W-1:0];
    assign below_ptr = cnt_q[PTR_W-1:0] - PTR_W'(2);

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign top   = top_q;

    // Storage array: written on push only, never reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Count and prefetched top: a pop reloads top from the entry beneath it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            top_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            top_q <= '0;
        end else if (push && !full) begin
            cnt_q <= cnt_q + CNT_W'(1);
            top_q <= push_data;
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CNT_W'(1);
            top_q <= (cnt_q >= CNT_W'(2)) ? mem[below_ptr] : '0;
        end
    end

endmodule

// File: rtl/lzw_string_unwind.sv
// Expands one LZW code by walking its prefix chain and streams the string out in forward order.
// Latency: first char 2n-1 cycles after accept for an n-char string; one char/cycle afterwards.
// Backpressure: char_ready low holds char_data/char_last; code_ready only high when idle.
module lzw_string_unwind #(
    parameter int CODE_W      = 12,
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    output logic              code_ready,
    output logic              dict_en,
    output logic [CODE_W-1:0] dict_addr,
    input  logic [DATA_W-1:0] dict_char,
    input  logic [CODE_W-1:0] dict_prefix,
    output logic              char_valid,
    output logic [DATA_W-1:0] char_data,
    output logic              char_last,
    input  logic              char_ready,
    output logic [DATA_W-1:0] first_char,
    output logic              overflow
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CODE_W-1:0] LIT = CODE_W'(lzw_pkg::LIT_LIMIT);

    lzw_pkg::state_t state_q, state_d;
    logic [CODE_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] first_q, first_d;
    logic              ovf_q, ovf_d;

    logic              stk_clear;
    logic              stk_push;
    logic [DATA_W-1:0] stk_push_data;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_top;
    logic [CNT_W-1:0]  stk_count;
    logic              stk_full;
    logic              stk_empty;

    lzw_char_stack #(
        .WIDTH (DATA_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (stk_clear),
        .push      (stk_push),
        .push_data (stk_push_data),
        .pop       (stk_pop),
        .top       (stk_top),
        .count     (stk_count),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // State, current chain code, first character and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= lzw_pkg::IDLE;
            cur_q   <= '0;
            first_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, dictionary strobe, stack control and output handshake.
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        first_d       = first_q;
        ovf_d         = ovf_q;
        stk_clear     = 1'b0;
        stk_push      = 1'b0;
        stk_push_data = '0;
        stk_pop       = 1'b0;
        dict_en       = 1'b0;
        dict_addr     = '0;
        code_ready    = 1'b0;
        char_valid    = 1'b0;
        char_last     = 1'b0;

        unique case (state_q)
            lzw_pkg::IDLE: begin
                code_ready = 1'b1;
                if (code_valid) begin
                    if (code < LIT) begin
                        // Literal: the stack is empty here, so this push cannot overflow.
                        stk_push      = 1'b1;
                        stk_push_data = code[DATA_W-1:0];
                        first_d       = code[DATA_W-1:0];
                        state_d       = lzw_pkg::POP;
                    end else begin
                        dict_en   = 1'b1;
                        dict_addr = code;
                        state_d   = lzw_pkg::LOOKUP;
                    end
                end
            end

            lzw_pkg::LOOKUP: begin
                if (stk_full) begin
                    ovf_d     = 1'b1;
                    stk_clear = 1'b1;
                    state_d   = lzw_pkg::IDLE;
                end else begin
                    stk_push      = 1'b1;
                    stk_push_data = dict_char;
                    cur_d         = dict_prefix;
                    state_d       = lzw_pkg::WALK;
                end
            end

            lzw_pkg::WALK: begin
                if (cur_q < LIT) begin
                    // Root character: the string is complete unless the stack has no room.
                    if (stk_full) begin
                        ovf_d     = 1'b1;
                        stk_clear = 1'b1;
                        state_d   = lzw_pkg::IDLE;
                    end else begin
                        stk_push      = 1'b1;
                        stk_push_data = cur_q[DATA_W-1:0];
                        first_d       = cur_q[DATA_W-1:0];
                        state_d       = lzw_pkg::POP;
                    end
                end else begin
                    dict_en   = 1'b1;
                    dict_addr = cur_q;
                    state_d   = lzw_pkg::LOOKUP;
                end
            end

            lzw_pkg::POP: begin
                char_valid = !stk_empty;
                char_last  = (stk_count == CNT_W'(1));
                if (char_ready && !stk_empty) begin
                    stk_pop = 1'b1;
                    if (stk_count == CNT_W'(1)) begin
                        state_d = lzw_pkg::IDLE;
                    end
                end
            end

            default: state_d = lzw_pkg::IDLE;
        endcase
    end

    assign char_data  = char_valid ? stk_top : '0;
    assign first_char = first_q;
    assign overflow   = ovf_q;

endmodule
